// File: rtl/fpu_issue_buffer_if.sv
// Core-to-buffer issue handshake and buffer-to-FPU dispatch bundle.
// slave = the issue buffer, master = the environment (core + FPU).
interface fpu_issue_buffer_if #(
  parameter int X_ID_WIDTH = 4,
  parameter int XLEN       = 32
);
  logic                  issue_valid;
  logic                  issue_ready;
  logic [31:0]           issue_instr;
  logic [X_ID_WIDTH-1:0] issue_id;
  logic [XLEN-1:0]       issue_rs;
  logic                  issue_accept;
  logic                  fpu_ready;
  logic                  fpu_enable;
  logic [31:0]           fpu_instruction;
  logic [X_ID_WIDTH-1:0] fpu_id;
  logic [XLEN-1:0]       fpu_data_fromXreg;

  modport slave (
    input  issue_valid, issue_instr, issue_id, issue_rs, fpu_ready,
    output issue_ready, issue_accept, fpu_enable, fpu_instruction, fpu_id, fpu_data_fromXreg
  );

  modport master (
    output issue_valid, issue_instr, issue_id, issue_rs, fpu_ready,
    input  issue_ready, issue_accept, fpu_enable, fpu_instruction, fpu_id, fpu_data_fromXreg
  );
endinterface

// File: rtl/fpu_issue_buffer.sv
// In-order FIFO between core offload and the FPU: decodes FP opcodes, buffers
// accepted {instr,id,rs} entries and dispatches one per cycle while the FPU is ready.
module fpu_issue_buffer #(
  parameter int DEPTH      = 4,
  parameter int X_ID_WIDTH = 4,
  parameter int XLEN       = 32
) (
  input  logic                       ck,
  input  logic                       reset,
  input  logic                       flush,
  fpu_issue_buffer_if.slave          bus,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [31:0]           instr;
    logic [X_ID_WIDTH-1:0] id;
    logic [XLEN-1:0]       rs;
  } entry_t;

  function automatic logic is_fp(input logic [6:0] op);
    case (op)
      7'b1010011, 7'b0000111, 7'b0100111,
      7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: is_fp = 1'b1;
      default:                                        is_fp = 1'b0;
    endcase
  endfunction

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            en_q;
  entry_t          out_q;
  logic            full, push, pop;

  assign full             = (count_q == CW'(DEPTH));
  assign bus.issue_ready  = ~reset & ~full;
  assign bus.issue_accept = bus.issue_valid & is_fp(bus.issue_instr[6:0]);

  // A handshake during flush completes on the bus but is dropped here.
  assign push = bus.issue_valid & bus.issue_ready & bus.issue_accept & ~flush;
  assign pop  = (count_q != '0) & bus.fpu_ready & ~flush;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge ck) begin
    if (push) mem_q[wr_ptr_q] <= '{instr: bus.issue_instr, id: bus.issue_id, rs: bus.issue_rs};
  end

  always_ff @(posedge ck) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      en_q     <= 1'b0;
      out_q    <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      en_q     <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        out_q    <= mem_q[rd_ptr_q];
      end
      count_q <= count_d;
      en_q    <= pop;
    end
  end

  assign bus.fpu_enable        = en_q;
  assign bus.fpu_instruction   = out_q.instr;
  assign bus.fpu_id            = out_q.id;
  assign bus.fpu_data_fromXreg = out_q.rs;
  assign count                 = count_q;
endmodule

// File: tb/tb_fpu_issue_buffer.sv
// Scoreboard bench: issues push expected dispatches into a queue, a negedge
// monitor pops and compares every fpu_enable beat.
module tb_fpu_issue_buffer;
  logic       ck = 1'b0;
  logic       reset, flush;
  logic [2:0] count;
  int         checks = 0, errors = 0, disp_cnt = 0;
  logic [67:0] exp_q[$];
  bit         stop;

  fpu_issue_buffer_if #(.X_ID_WIDTH(4), .XLEN(32)) bus();

  fpu_issue_buffer #(.DEPTH(4), .X_ID_WIDTH(4), .XLEN(32)) dut (
    .ck(ck), .reset(reset), .flush(flush), .bus(bus.slave), .count(count)
  );

  always #5 ck = ~ck;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  always @(negedge ck) begin
    if (!reset && bus.fpu_enable === 1'b1) begin
      disp_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL dispatch_unexpected: got instr 0x%0h id %0d expected no dispatch",
                 bus.fpu_instruction, bus.fpu_id);
      end else begin
        logic [67:0] e;
        e = exp_q.pop_front();
        if ({bus.fpu_instruction, bus.fpu_id, bus.fpu_data_fromXreg} !== e) begin
          errors++;
          $display("FAIL dispatch_data: got %h/%0d/%h expected %h/%0d/%h",
                   bus.fpu_instruction, bus.fpu_id, bus.fpu_data_fromXreg,
                   e[67:36], e[35:32], e[31:0]);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] ins, input logic [3:0] id, input logic [31:0] rs,
                       input logic exp_acc);
    int b;
    bus.issue_instr = ins; bus.issue_id = id; bus.issue_rs = rs; bus.issue_valid = 1'b1;
    #1;
    b = 0;
    while (!bus.issue_ready && b < 20) begin
      @(posedge ck); #1; b++;
    end
    if (b == 20) begin
      checks++; errors++;
      $display("FAIL issue_timeout: got issue_ready=0 expected 1 within 20 cycles");
      bus.issue_valid = 1'b0;
      return;
    end
    chk("issue_accept", 32'(bus.issue_accept), 32'(exp_acc));
    if (exp_acc) exp_q.push_back({ins, id, rs});
    @(posedge ck); #1;
    bus.issue_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int b = 0;
    while (exp_q.size() != 0 && b < 100) begin
      @(posedge ck); b++;
    end
    chk("drain_remaining", exp_q.size(), 0);
    repeat (2) @(posedge ck);
    #1;
  endtask

  initial begin
    int base;
    reset = 1'b1; flush = 1'b0; stop = 1'b0;
    bus.issue_valid = 1'b1; bus.issue_instr = 32'h00208053; bus.issue_id = '0;
    bus.issue_rs = '0; bus.fpu_ready = 1'b1;

    // 1 reset
    repeat (2) begin
      @(posedge ck); #1;
      chk("rst_issue_ready", 32'(bus.issue_ready), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_fpu_enable", 32'(bus.fpu_enable), 0);
    end
    bus.issue_valid = 1'b0;
    reset = 1'b0;
    @(posedge ck); #1;

    // 2 single fadd.s
    issue(32'h00208053, 4'd3, 32'h1234_5678, 1'b1);
    @(posedge ck); #1;
    chk("single_enable", 32'(bus.fpu_enable), 1);
    chk("single_instr", bus.fpu_instruction, 32'h00208053);
    chk("single_id", 32'(bus.fpu_id), 3);
    @(posedge ck); #1;
    chk("single_enable_pulse", 32'(bus.fpu_enable), 0);

    // 3 reject integer add
    issue(32'h00000033, 4'd5, 32'h0, 1'b0);
    chk("reject_count", 32'(count), 0);
    repeat (3) @(posedge ck);
    #1;

    // 4 full / stall
    bus.fpu_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(32'h00000007 | (i << 7), 4'(i), 32'(100 + i), 1'b1);
    chk("full_count", 32'(count), 4);
    chk("full_issue_ready", 32'(bus.issue_ready), 0);
    base = disp_cnt;
    fork
      issue(32'h00000027 | (4 << 7), 4'd4, 32'd104, 1'b1);
      begin
        bus.fpu_ready = 1'b1;
        repeat (5) @(posedge ck);
        chk("b2b_dispatch_4", 32'(disp_cnt - base), 4);
      end
    join
    wait_drain();

    // 5 wrap with fpu_ready toggling
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          logic [31:0] ins;
          ins = (i % 2) ? 32'h0000004B : 32'h00000053;
          issue(ins | (32'(i) << 20), 4'(i), 32'hA000 + 32'(i), 1'b1);
          checks++;
          if (count > 3'd4) begin
            errors++;
            $display("FAIL wrap_count: got %0d expected <= 4", count);
          end
        end
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          @(posedge ck); #1;
          bus.fpu_ready = ~bus.fpu_ready;
        end
      end
    join
    bus.fpu_ready = 1'b1;
    wait_drain();

    // 6 flush with 3 queued, plus a handshake inside the flush cycle
    bus.fpu_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(32'h00000043, 4'(8 + i), 32'(i), 1'b1);
    chk("flush_pre_count", 32'(count), 3);
    flush = 1'b1;
    bus.issue_instr = 32'h00000053; bus.issue_id = 4'hF; bus.issue_valid = 1'b1;
    #1;
    chk("flush_issue_ready", 32'(bus.issue_ready), 1);
    @(posedge ck); #1;
    flush = 1'b0; bus.issue_valid = 1'b0;
    exp_q.delete();
    chk("flush_count", 32'(count), 0);
    chk("flush_enable", 32'(bus.fpu_enable), 0);
    bus.fpu_ready = 1'b1;
    base = disp_cnt;
    repeat (5) @(posedge ck);
    chk("flush_no_dispatch", 32'(disp_cnt - base), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got no finish expected finish by 50000");
    $fatal(1);
  end
endmodule
